// File: rtl/apb_vga_sync_if.sv
// APB3 slave bus bundle for apb_vga_sync.
//   paddr   : register address (bits [3:2] select the register)
//   pwdata  : write data
//   pwrite  : 1 = write access
//   psel    : peripheral select
//   penable : access phase
//   prdata  : read data (combinational from register state)
//   pready  : always ready
//   pslverr : never errors
interface apb_vga_sync_if #(
  parameter int APB_ADDR_WIDTH = 12
) ();
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [31:0]               pwdata;
  logic                      pwrite;
  logic                      psel;
  logic                      penable;
  logic [31:0]               prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    output paddr, pwdata, pwrite, psel, penable,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, pwdata, pwrite, psel, penable,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_vga_sync.sv
// APB-programmable VGA timing and pattern generator (640x480@60 by default).
// A clock divider produces a pixel tick; horizontal/vertical counters advance
// on each tick and the registered sync/colour outputs load the decode of the
// current (h,v), so the pads lag the POS register by one pixel.
//   clk_i    : system clock (only clock)
//   rst_n    : synchronous active-low reset
//   apb      : APB slave bus (CTRL, COLOR, STATUS, POS registers)
//   irq_o    : one-cycle frame-done pulse
//   vga_hs_o : horizontal sync, active-low
//   vga_vs_o : vertical sync, active-low
//   rgb_o    : {R[3:0],G[3:0],B[3:0]}
module apb_vga_sync #(
  parameter int PIX_DIV        = 4,
  parameter int H_VIS          = 640,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_VIS          = 480,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                 clk_i,
  input  logic                 rst_n,
  apb_vga_sync_if.slave        apb,
  output logic                 irq_o,
  output logic                 vga_hs_o,
  output logic                 vga_vs_o,
  output logic [11:0]          rgb_o
);

  localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
  localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
  localparam logic [9:0] HS_BEG   = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG   = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC - 1);

  // Programmable registers
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic [11:0]      color_q, color_d;
  logic             fd_q, fd_d;
  // Frame-stable copies of MODE/COLOR
  logic [1:0]       mode_act_q;
  logic [11:0]      color_act_q;
  // Timing state
  logic [DIV_W-1:0] div_cnt_q;
  logic [9:0]       h_cnt_q;
  logic [9:0]       v_cnt_q;
  // Registered pad outputs
  logic             hs_q, vs_q, irq_q;
  logic [11:0]      rgb_q;

  logic             wr, wr_ctrl, wr_color, wr_stat;
  logic [1:0]       reg_sel;
  logic             tick, frame_start, frame_end, vblank;
  logic [1:0]       mode_use;
  logic [11:0]      color_use;
  logic [11:0]      pix_rgb;
  logic             hs_n, vs_n;
  logic [31:0]      rdata;
  logic             unused_bits;

  function automatic logic [11:0] bar_color(input logic [9:0] h);
    case (h / 10'd80)
      10'd0:   bar_color = 12'hFFF;
      10'd1:   bar_color = 12'hFF0;
      10'd2:   bar_color = 12'h0FF;
      10'd3:   bar_color = 12'h0F0;
      10'd4:   bar_color = 12'hF0F;
      10'd5:   bar_color = 12'hF00;
      10'd6:   bar_color = 12'h00F;
      default: bar_color = 12'h000;
    endcase
  endfunction

  assign reg_sel  = apb.paddr[3:2];
  assign wr       = apb.psel & apb.penable & apb.pwrite;
  assign wr_ctrl  = wr & (reg_sel == 2'd0);
  assign wr_color = wr & (reg_sel == 2'd1);
  assign wr_stat  = wr & (reg_sel == 2'd2);

  assign en_d    = wr_ctrl  ? apb.pwdata[0]    : en_q;
  assign mode_d  = wr_ctrl  ? apb.pwdata[2:1]  : mode_q;
  assign color_d = wr_color ? apb.pwdata[11:0] : color_q;

  // Ticks stop on the very edge that clears EN, so a disable write never
  // coincides with a frame-done event.
  assign tick        = en_q & en_d & (div_cnt_q == DIV_LAST);
  assign frame_start = (h_cnt_q == 10'd0) & (v_cnt_q == 10'd0);
  assign frame_end   = tick & (h_cnt_q == H_LAST) & (v_cnt_q == V_LAST);
  assign vblank      = (v_cnt_q >= V_VIS_C);

  // Set beats a simultaneous write-one-to-clear.
  assign fd_d = frame_end | (fd_q & ~(wr_stat & apb.pwdata[0]));

  // Pixel (0,0) is decoded on the same tick that loads the shadow copies,
  // so it must already see the newly programmed values.
  assign mode_use  = frame_start ? mode_q  : mode_act_q;
  assign color_use = frame_start ? color_q : color_act_q;

  assign hs_n = ~((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
  assign vs_n = ~((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));

  always_comb begin
    pix_rgb = 12'h000;
    if ((h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C)) begin
      case (mode_use)
        2'd0:    pix_rgb = color_use;
        2'd1:    pix_rgb = bar_color(h_cnt_q);
        2'd2:    pix_rgb = (h_cnt_q[5] ^ v_cnt_q[5]) ? color_use : 12'h000;
        default: pix_rgb = 12'h000;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      en_q        <= 1'b0;
      mode_q      <= 2'd0;
      color_q     <= 12'h000;
      fd_q        <= 1'b0;
      mode_act_q  <= 2'd0;
      color_act_q <= 12'h000;
      div_cnt_q   <= '0;
      h_cnt_q     <= 10'd0;
      v_cnt_q     <= 10'd0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      rgb_q       <= 12'h000;
      irq_q       <= 1'b0;
    end else begin
      en_q    <= en_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      fd_q    <= fd_d;
      irq_q   <= frame_end;
      if (!en_d) begin
        div_cnt_q <= '0;
        h_cnt_q   <= 10'd0;
        v_cnt_q   <= 10'd0;
        hs_q      <= 1'b1;
        vs_q      <= 1'b1;
        rgb_q     <= 12'h000;
      end else if (en_q) begin
        // On the enabling edge itself (en_q still 0) everything stays at
        // zero, so the first tick lands PIX_DIV cycles after the write.
        div_cnt_q <= tick ? '0 : div_cnt_q + DIV_W'(1);
        if (tick) begin
          hs_q  <= hs_n;
          vs_q  <= vs_n;
          rgb_q <= pix_rgb;
          if (frame_start) begin
            mode_act_q  <= mode_q;
            color_act_q <= color_q;
          end
          if (h_cnt_q == H_LAST) begin
            h_cnt_q <= 10'd0;
            v_cnt_q <= (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
          end else begin
            h_cnt_q <= h_cnt_q + 10'd1;
          end
        end
      end
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (apb.psel) begin
      case (reg_sel)
        2'd0:    rdata[2:0]  = {mode_q, en_q};
        2'd1:    rdata[11:0] = color_q;
        2'd2:    rdata[1:0]  = {vblank, fd_q};
        default: rdata       = {6'd0, v_cnt_q, 6'd0, h_cnt_q};
      endcase
    end
  end

  assign apb.prdata  = rdata;
  assign apb.pready  = 1'b1;
  assign apb.pslverr = 1'b0;

  assign irq_o    = irq_q;
  assign vga_hs_o = hs_q;
  assign vga_vs_o = vs_q;
  assign rgb_o    = rgb_q;

  // Address/data bits outside the decoded register map.
  assign unused_bits = ^{apb.pwdata[31:12], apb.paddr[APB_ADDR_WIDTH-1:4],
                         apb.paddr[1:0]};

endmodule

// File: tb/tb_apb_vga_sync.sv
// Directed bench for apb_vga_sync with a shortened vertical timing
// (PIX_DIV=2, 800 pixels x 7 lines => 11200 clocks per frame).
module tb_apb_vga_sync;
  localparam int PD  = 2;
  localparam int VV  = 4;
  localparam int VFP = 1;
  localparam int VSY = 1;
  localparam int VBP = 1;
  localparam int FRAME = 800 * (VV + VFP + VSY + VBP) * PD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        irq, hs, vs;
  logic [11:0] rgb;

  apb_vga_sync_if #(.APB_ADDR_WIDTH(12)) bus ();

  apb_vga_sync #(
    .PIX_DIV(PD), .H_VIS(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_VIS(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP), .APB_ADDR_WIDTH(12)
  ) dut (
    .clk_i(clk), .rst_n(rst_n), .apb(bus),
    .irq_o(irq), .vga_hs_o(hs), .vga_vs_o(vs), .rgb_o(rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  // Clocks since the last frame-done pulse (1 on the edge after irq).
  int jf = 100000;
  always @(posedge clk) jf <= irq ? 1 : jf + 1;

  typedef struct {
    logic [11:0] waddr;
    logic [11:0] raddr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } reg_vec_t;

  typedef struct {
    int          j;
    logic [11:0] exp;
  } pix_vec_t;

  reg_vec_t regv[10];
  pix_vec_t bars[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = 12'hC; bus.pwdata = 32'h0;
  endtask

  // Called at a negedge; the write takes effect on the 2nd posedge and the
  // task returns on the negedge right after it.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    bus.paddr = a; bus.pwdata = d; bus.pwrite = 1'b1; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.penable = 1'b1;
    @(posedge clk); @(negedge clk);
    bus_idle();
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    bus.paddr = a; bus.pwrite = 1'b0; bus.psel = 1'b1; bus.penable = 1'b0;
    @(posedge clk); @(negedge clk);
    bus.penable = 1'b1;
    d = bus.prdata;
    @(posedge clk); @(negedge clk);
    bus_idle();
  endtask

  task automatic wait_j(input int target);
    int n = 0;
    while (jf != target && n < 2 * FRAME) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("frame_pos_%0d", target), jf, target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] rd;
  int n, n_hs, n_vs, n_grn, n_bad, n_irq, n_pr, n_idle, fall1, fall2, run1;
  logic prev_hs, in1;
  logic [11:0] r1, r2;

  initial begin
    regv[0] = '{12'h000, 12'h000, 32'h0000_0006, 32'h6};
    regv[1] = '{12'h000, 12'h000, 32'hFFFF_FFFE, 32'h6};
    regv[2] = '{12'h000, 12'h000, 32'h0000_0002, 32'h2};
    regv[3] = '{12'h004, 12'h004, 32'h0000_0ABC, 32'hABC};
    regv[4] = '{12'h004, 12'h004, 32'hFFFF_F123, 32'h123};
    regv[5] = '{12'h00C, 12'h00C, 32'hFFFF_FFFF, 32'h0};
    regv[6] = '{12'h008, 12'h008, 32'h0000_0003, 32'h0};
    regv[7] = '{12'h010, 12'h000, 32'h0000_0004, 32'h4};
    regv[8] = '{12'h014, 12'h004, 32'h0000_0555, 32'h555};
    regv[9] = '{12'h000, 12'h000, 32'h0000_0000, 32'h0};

    // Pixel (h,v) of the frame is visible at jf = 2*(v*800+h)+2.
    bars[0]  = '{2,    12'hFFF};
    bars[1]  = '{160,  12'hFFF};
    bars[2]  = '{162,  12'hFF0};
    bars[3]  = '{322,  12'h0FF};
    bars[4]  = '{482,  12'h0F0};
    bars[5]  = '{642,  12'hF0F};
    bars[6]  = '{802,  12'hF00};
    bars[7]  = '{962,  12'h00F};
    bars[8]  = '{1120, 12'h00F};
    bars[9]  = '{1122, 12'h000};
    bars[10] = '{1282, 12'h000};
    bars[11] = '{1802, 12'hFF0};

    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_hs", hs, 1); chk("reset_vs", vs, 1);
    chk("reset_rgb", rgb, 0); chk("reset_irq", irq, 0);
    rst_n = 1'b1;

    // Idle after reset
    n_idle = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (hs !== 1'b1 || vs !== 1'b1 || rgb !== 12'h0 || irq !== 1'b0 || bus.prdata !== 32'h0) n_idle++;
    end
    chk("idle_outputs_bad_cycles", n_idle, 0);
    apb_read(12'h8, rd); chk("idle_status", rd, 0);
    apb_read(12'hC, rd); chk("idle_pos", rd, 0);

    // Register access table (EN kept 0)
    for (int i = 0; i < 10; i++) begin
      apb_write(regv[i].waddr, regv[i].wdata);
      apb_read(regv[i].raddr, rd);
      chk($sformatf("reg_vec_%0d", i), rd, regv[i].exp);
    end

    // Solid green, enable
    apb_write(12'h4, 32'h0F0);
    apb_write(12'h0, 32'h1);
    n = 0;
    while (irq !== 1'b1 && n < 2 * FRAME) begin @(negedge clk); n++; end
    chk("first_irq_latency", n, FRAME);

    // One full frame of measurements
    n_hs = 0; n_vs = 0; n_grn = 0; n_bad = 0; n_irq = 0; n_pr = 0;
    fall1 = -1; fall2 = -1; run1 = 0; prev_hs = 1'b1; in1 = 1'b0;
    for (int j = 1; j <= FRAME; j++) begin
      @(negedge clk);
      if (!hs) n_hs++;
      if (!vs) n_vs++;
      if (rgb == 12'h0F0) n_grn++; else if (rgb != 12'h0) n_bad++;
      if (irq) n_irq++;
      if (bus.prdata != 32'h0) n_pr++;
      if (prev_hs && !hs) begin
        if (fall1 < 0) begin fall1 = j; in1 = 1'b1; end
        else if (fall2 < 0) fall2 = j;
      end
      if (!prev_hs && hs) in1 = 1'b0;
      if (in1 && !hs) run1++;
      prev_hs = hs;
    end
    chk("irq_at_frame_end", irq, 1);
    chk("irq_count_frame", n_irq, 1);
    chk("hs_low_clocks_frame", n_hs, 96 * PD * 7);
    chk("hs_first_fall", fall1, 2 * 656 + 2);
    chk("line_period", fall2 - fall1, 800 * PD);
    chk("hs_low_run", run1, 96 * PD);
    chk("vs_low_clocks", n_vs, 800 * PD * VSY);
    chk("rgb_green_clocks", n_grn, 640 * VV * PD);
    chk("rgb_other_clocks", n_bad, 0);
    chk("prdata_unselected", n_pr, 0);
    @(negedge clk);
    chk("irq_one_cycle", irq, 0);
    apb_read(12'h8, rd); chk("status_after_frame", rd, 1);
    apb_write(12'h8, 32'h1);
    apb_read(12'h8, rd); chk("status_after_w1c", rd, 0);

    // Mid-frame colour change must wait for the next frame
    wait_j(3201);
    apb_read(12'hC, rd); chk("pos_v2_h1", rd, 32'h0002_0001);
    wait_j(3300);
    apb_write(12'h4, 32'hF00);
    wait_j(6080);
    chk("old_color_last_visible", rgb, 12'h0F0);
    wait_j(6500);
    apb_read(12'h8, rd); chk("status_vblank", rd, 2);
    wait_j(2);
    chk("new_color_first_pixel", rgb, 12'hF00);

    // W1C landing on the exact frame-done edge
    apb_write(12'h8, 32'h1);
    apb_read(12'h8, rd); chk("status_cleared", rd, 0);
    apb_write(12'h0, 32'h3);
    wait_j(FRAME - 2);
    apb_write(12'h8, 32'h1);
    chk("irq_on_w1c_edge", irq, 1);

    // Colour bars (mode shadowed in at this frame start)
    for (int i = 0; i < 12; i++) begin
      wait_j(bars[i].j);
      chk($sformatf("bars_j%0d", bars[i].j), rgb, bars[i].exp);
    end
    apb_read(12'h8, rd); chk("status_set_wins", rd, 1);
    apb_write(12'h8, 32'h1);
    apb_read(12'h8, rd); chk("status_late_w1c", rd, 0);

    // Disable during hsync+vsync
    n = 0;
    while (!(hs === 1'b0 && vs === 1'b0) && n < 2 * FRAME) begin @(negedge clk); n++; end
    chk("sync_low_found", {hs, vs}, 2'b00);
    apb_write(12'h0, 32'h0);
    chk("dis_hs", hs, 1); chk("dis_vs", vs, 1);
    chk("dis_rgb", rgb, 0); chk("dis_irq", irq, 0);
    apb_read(12'hC, rd); chk("dis_pos", rd, 0);

    // Re-enable: first tick PD clocks later, hs falls at pixel 656
    apb_write(12'h0, 32'h1);
    n = 0; r1 = 12'hABC; r2 = 12'hABC;
    while (hs === 1'b1 && n < 2 * FRAME) begin
      @(negedge clk); n++;
      if (n == 1) r1 = rgb;
      if (n == 2) r2 = rgb;
    end
    chk("reen_rgb_before_tick", r1, 12'h000);
    chk("reen_rgb_first_tick", r2, 12'hF00);
    chk("reen_first_hs_fall", n, PD + 656 * PD);

    // Reset in the middle of a visible line
    n = 0;
    while (rgb === 12'h0 && n < 2 * FRAME) begin @(negedge clk); n++; end
    chk("visible_before_reset", rgb, 12'hF00);
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_hs", hs, 1); chk("rst_vs", vs, 1); chk("rst_rgb", rgb, 0);
    rst_n = 1'b1;
    apb_read(12'h0, rd); chk("rst_ctrl", rd, 0);
    apb_read(12'h4, rd); chk("rst_color", rd, 0);
    apb_read(12'hC, rd); chk("rst_pos", rd, 0);
    apb_read(12'h8, rd); chk("rst_status", rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_vga_sync.md
# apb_vga_sync

APB-programmable VGA 640x480@60 timing and pattern generator in the peripherals subsystem. It divides the system clock into a pixel enable and runs horizontal and vertical counters. It drives the chip-level vga_hs_o, vga_vs_o and rgb_o pads and raises a frame-done interrupt into the event unit.

## Interface
Parameters:
- PIX_DIV, 4: clk_i cycles per pixel (100 MHz -> 25 MHz); must be >= 1.
- H_VIS, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal timing in pixels.
- V_VIS, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical timing in lines.
- APB_ADDR_WIDTH, 12: APB address width.

Ports:
- clk_i  in  1  system clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- paddr  in  APB_ADDR_WIDTH  APB address; bits [3:2] decoded.
- pwdata  in  32  APB write data.
- pwrite  in  1  APB write.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- prdata  out  32  APB read data.
- pready  out  1  tied 1.
- pslverr  out  1  tied 0.
- irq_o  out  1  one-clk frame-done pulse.
- vga_hs_o  out  1  hsync, active-low.
- vga_vs_o  out  1  vsync, active-low.
- rgb_o  out  12  {R[3:0],G[3:0],B[3:0]}.

## Operation
- Registers (write on psel&penable&pwrite):
  - 0x0 CTRL: [0] EN, [2:1] MODE.
  - 0x4 COLOR: [11:0].
  - 0x8 STATUS: [0] FRAME_DONE (sticky, W1C); [1] VBLANK (live, v >= V_VIS, read-only).
  - 0xC POS (read-only): [9:0] h_cnt, [25:16] v_cnt.
  - Unused bits read 0. Reads are combinational from register state.
- Shadowing: MODE and COLOR are copied into active copies on the pixel tick where h=0 and v=0, so writes never tear a frame.
- Pixel divider:
  - div_cnt counts 0..PIX_DIV-1.
  - tick is asserted when div_cnt==PIX_DIV-1. If PIX_DIV=1, tick is asserted every cycle.
- Counters:
  - On tick, h_cnt increments. H_TOT = H_VIS+H_FP+H_SYNC+H_BP = 800.
  - At H_TOT-1, h_cnt wraps to 0 and v_cnt increments. v_cnt wraps to 0 after V_TOT-1 = 524.
- Sync decode from current (h,v):
  - hs low for h in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC-1] = 656..751.
  - vs low for v in [490, 491].
- Pixel colour, when h < H_VIS and v < V_VIS (otherwise 0):
  - MODE 0, solid: active COLOR.
  - MODE 1, bars: bar index = h/80, giving FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - MODE 2, checker: (h[5]^v[5]) ? COLOR : 000.
  - MODE 3: 000.
- Frame done: on the tick with h=H_TOT-1 and v=V_TOT-1, FRAME_DONE is set and irq_o pulses for one clk_i cycle.
- Disable (EN=0):
  - div_cnt, h_cnt and v_cnt are held at 0.
  - hs=vs=1, rgb=0, no irq.
  - Clearing EN mid-frame takes effect on the next clk_i edge.

## Timing
- Reset values: all registers 0, active MODE/COLOR 0, counters 0, vga_hs_o=1, vga_vs_o=1, rgb_o=0, irq_o=0, prdata=0 while unselected.
- Outputs are registered. On tick, the outputs load the decode of the current (h,v) and the counters advance on the same edge. Outputs therefore lag POS by one pixel.
- EN 0->1: the first tick is PIX_DIV cycles after the write edge. The shadow load occurs on that first tick, since (h,v)=(0,0).
- Simultaneous W1C and frame-done set: set wins.
- A reset asserted mid-frame returns all state to the reset values on the next edge.
- Frame period = 800*525*PIX_DIV clk_i cycles (1,680,000 at default).

## Test plan
- Reset, no writes -> hs=1, vs=1, rgb=000, irq=0, STATUS=0, all for 10k cycles.
- CTRL=1, COLOR=0x0F0, PIX_DIV=4 -> hs low for exactly 384 clk per line, line period 3200 clk, vs low for exactly 2 lines, rgb=0F0 only in visible region.
- MODE=1 -> sampled rgb at h=0,80,…,560 = FFF,FF0,0FF,0F0,F0F,F00,00F,000; rgb=000 for h>=640.
- Write COLOR=0xF00 at mid-frame (v=200) -> rgb stays at the old colour until the next frame's first pixel, then becomes F00.
- Frame end -> irq one-cycle pulse, STATUS[0]=1. A W1C on the exact set cycle leaves it 1; a W1C later clears it to 0.
- Write CTRL=0 at v=300 -> next edge POS=0, hs=vs=1, rgb=000. Re-enable -> the first hs low begins 656 pixels after the first tick.
